pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline; sits beside the forwarding unit.
- Covers the hazards forwarding cannot resolve:
  - load-use: one-cycle bubble;
  - EX-stage redirect: flush IF/ID and ID/EX;
  - data-bus wait: full-pipeline freeze with timeout;
  - debug halt: drain and park.
- Drives stall/flush/redirect controls of PC, IF/ID, ID/EX, EX/MEM, MEM/WB; keeps saturating performance counters.

Parameters:
TIMEOUT, 16, max consecutive MEM_WAIT cycles before the bus is declared hung (WAIT_W = clog2(TIMEOUT+1))
DRAIN_CYC, 3, forward-progress cycles needed to empty ID..MEM after halt
CNT_W, 32, width of perf counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
id_rs1  in  5  source reg 1 of instr in ID
id_rs2  in  5  source reg 2 of instr in ID
id_use_rs1  in  1  ID instr reads rs1
id_use_rs2  in  1  ID instr reads rs2
ex_rd  in  5  dest reg of instr in EX
ex_is_load  in  1  EX instr is a load
ex_redirect  in  1  EX branch taken / jal / jalr
mem_req  in  1  MEM stage has a data-bus access outstanding
mem_ack  in  1  data bus completes access this cycle
halt_req  in  1  debug halt request (level)
resume  in  1  leave HALTED
pc_stall  out  1  hold PC
pc_redirect  out  1  PC loads EX target (overrides pc_stall)
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  IF/ID becomes bubble
id_ex_stall  out  1  hold ID/EX
id_ex_flush  out  1  ID/EX becomes bubble
ex_mem_stall  out  1  hold EX/MEM
mem_wb_flush  out  1  MEM/WB becomes bubble
halted  out  1  core parked
mem_timeout  out  1  sticky bus-hang flag
stall_cnt  out  CNT_W  cycles stalled (load-use + mem wait)
flush_cnt  out  CNT_W  redirect events

Behaviour:
- Sync reset, active-high. While rst=1:
  - state=RUN; wait_cnt, drain_cnt, counters, mem_timeout = 0.
  - All control outputs forced 0.
- Combinational terms:
  - mem_wait = mem_req & ~mem_ack.
  - load_use = ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Control outputs are combinational from state + inputs (zero latency). State/counters update on clk.
- Freeze set: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_flush = 1.
- Priority every cycle: mem_wait > ex_redirect > load_use > halt_req.
- RUN:
  - mem_wait: freeze set; wait_cnt<=1; ->MEM_WAIT.
  - ex_redirect: pc_redirect, if_id_flush, id_ex_flush = 1; flush_cnt++.
  - load_use: pc_stall, if_id_stall, id_ex_flush = 1; stall_cnt++.
  - halt_req: pc_stall, if_id_flush = 1; drain_cnt<=0; ->DRAIN.
- MEM_WAIT:
  - mem_wait: freeze set; stall_cnt++; wait_cnt++.
  - wait_cnt==TIMEOUT and still mem_wait: mem_timeout<=1 (sticky until rst); ->HALTED.
  - ~mem_wait (ack or req dropped): outputs evaluated exactly as RUN this cycle; ->RUN; wait_cnt<=0.
- DRAIN:
  - Base outputs: pc_stall=1, if_id_flush=1.
  - mem_wait: freeze set (if_id_flush suppressed); counter held. Also counts toward timeout via wait_cnt, same rule as MEM_WAIT.
  - load_use: if_id_stall=1, id_ex_flush=1, if_id_flush suppressed; drain_cnt held.
  - ex_redirect: pc_redirect, id_ex_flush = 1; flush_cnt++; drain_cnt++.
  - Otherwise drain_cnt++.
  - drain_cnt reaching DRAIN_CYC ->HALTED.
- HALTED:
  - halted=1, pc_stall=1, if_id_flush=1.
  - resume -> RUN next cycle; halted drops that edge.
  - halt_req ignored while HALTED.
  - resume in any other state ignored.
- halt_req deasserted during DRAIN does not abort the drain.
- Counters saturate at all-ones, never wrap. Simultaneous mem_wait+load_use counts once.
- ex_rd==0 never causes load_use.

Decomposition:
- Shared package (pipe_ctrl_pkg): state encoding (RUN=2'd0, MEM_WAIT=2'd1, DRAIN=2'd2, HALTED=2'd3) and the freeze/bubble control-vector bit indices.
- One sub-module: sat_counter (CNT_W, inc, clear), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Load-use: EX lw x5, ID add x6,x5,x1 -> one cycle pc_stall=if_id_stall=id_ex_flush=1, stall_cnt=1; lw x0 same pattern -> no stall.
- Redirect + load_use same cycle -> only pc_redirect, if_id_flush, id_ex_flush; flush_cnt=1, stall_cnt=0.
- mem_req held 4 cycles, ack on 5th -> freeze for 4 cycles, back to RUN on ack cycle, stall_cnt=4.
- mem_req, no ack for TIMEOUT=16 cycles -> mem_timeout=1, halted=1 next cycle; only rst clears mem_timeout.
- halt_req pulse in RUN -> DRAIN 3 progress cycles, halted=1; a 2-cycle mem wait inside DRAIN delays halted by 2; resume -> halted=0 next cycle.
- Assert rst mid-MEM_WAIT -> next cycle all outputs 0, counters 0, state RUN.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM state encoding and
// the bit layout of the stall/flush/redirect control vector.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_e;

    localparam int CTL_W            = 8;
    localparam int CTL_PC_STALL     = 0;
    localparam int CTL_PC_REDIRECT  = 1;
    localparam int CTL_IF_ID_STALL  = 2;
    localparam int CTL_IF_ID_FLUSH  = 3;
    localparam int CTL_ID_EX_STALL  = 4;
    localparam int CTL_ID_EX_FLUSH  = 5;
    localparam int CTL_EX_MEM_STALL = 6;
    localparam int CTL_MEM_WB_FLUSH = 7;

    typedef logic [CTL_W-1:0] ctl_t;

    localparam ctl_t M_PC_STALL     = ctl_t'(1) << CTL_PC_STALL;
    localparam ctl_t M_PC_REDIRECT  = ctl_t'(1) << CTL_PC_REDIRECT;
    localparam ctl_t M_IF_ID_STALL  = ctl_t'(1) << CTL_IF_ID_STALL;
    localparam ctl_t M_IF_ID_FLUSH  = ctl_t'(1) << CTL_IF_ID_FLUSH;
    localparam ctl_t M_ID_EX_STALL  = ctl_t'(1) << CTL_ID_EX_STALL;
    localparam ctl_t M_ID_EX_FLUSH  = ctl_t'(1) << CTL_ID_EX_FLUSH;
    localparam ctl_t M_EX_MEM_STALL = ctl_t'(1) << CTL_EX_MEM_STALL;
    localparam ctl_t M_MEM_WB_FLUSH = ctl_t'(1) << CTL_MEM_WB_FLUSH;

    // Whole-pipe freeze: hold every register and let a bubble fall out of MEM/WB.
    localparam ctl_t CTL_FREEZE = M_PC_STALL | M_IF_ID_STALL | M_ID_EX_STALL
                                | M_EX_MEM_STALL | M_MEM_WB_FLUSH;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (inc && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    // NOTE: clear is synchronous; it only takes effect on a rising clock edge.
    always_ff @(posedge clk) begin
        if (clear) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, EX redirects,
// data-bus wait freeze with hang timeout, and debug halt drain/park.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT   = 16,
    parameter int DRAIN_CYC = 3,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ack,
    input  logic             halt_req,
    input  logic             resume,
    output logic             pc_stall,
    output logic             pc_redirect,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_wb_flush,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W  = $clog2(TIMEOUT + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYC + 1);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d, wait_inc;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d, drain_inc;
    logic               mem_timeout_q, mem_timeout_d;
    logic               mem_wait, load_use, wait_hung, drain_done;
    logic               stall_inc, flush_inc;
    ctl_t               run_ctl, ctl;

    assign mem_wait = mem_req & ~mem_ack;
    assign load_use = ex_is_load && (ex_rd != 5'd0)
                   && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));

    assign wait_inc   = wait_cnt_q + WAIT_W'(1);
    assign wait_hung  = (wait_inc == WAIT_W'(TIMEOUT));
    assign drain_inc  = drain_cnt_q + DRAIN_W'(1);
    assign drain_done = (drain_inc == DRAIN_W'(DRAIN_CYC));

    // Priority: mem_wait > ex_redirect > load_use > halt_req.
    always_comb begin
        if (mem_wait)         run_ctl = CTL_FREEZE;
        else if (ex_redirect) run_ctl = M_PC_REDIRECT | M_IF_ID_FLUSH | M_ID_EX_FLUSH;
        else if (load_use)    run_ctl = M_PC_STALL | M_IF_ID_STALL | M_ID_EX_FLUSH;
        else if (halt_req)    run_ctl = M_PC_STALL | M_IF_ID_FLUSH;
        else                  run_ctl = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            drain_cnt_q   <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        drain_cnt_d   = drain_cnt_q;
        mem_timeout_d = mem_timeout_q;
        unique case (state_q)
            RUN: begin
                if (mem_wait) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end else if (!ex_redirect && !load_use && halt_req) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (!mem_wait) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_hung) begin
                    state_d       = HALTED;
                    mem_timeout_d = 1'b1;
                    wait_cnt_d    = '0;
                end else begin
                    wait_cnt_d = wait_inc;
                end
            end
            DRAIN: begin
                if (mem_wait) begin
                    if (wait_hung) begin
                        state_d       = HALTED;
                        mem_timeout_d = 1'b1;
                        wait_cnt_d    = '0;
                    end else begin
                        wait_cnt_d = wait_inc;
                    end
                end else begin
                    wait_cnt_d = '0;
                    // A load-use bubble is not forward progress; a redirect is.
                    if (ex_redirect || !load_use) begin
                        drain_cnt_d = drain_inc;
                        if (drain_done) state_d = HALTED;
                    end
                end
            end
            HALTED: begin
                if (resume) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        ctl       = '0;
        halted    = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (!rst) begin
            unique case (state_q)
                RUN, MEM_WAIT: begin
                    ctl       = run_ctl;
                    stall_inc = mem_wait || (load_use && !ex_redirect);
                    flush_inc = ex_redirect && !mem_wait;
                end
                DRAIN: begin
                    if (mem_wait) begin
                        ctl       = CTL_FREEZE;
                        stall_inc = 1'b1;
                    end else if (ex_redirect) begin
                        ctl       = M_PC_STALL | M_IF_ID_FLUSH | M_PC_REDIRECT | M_ID_EX_FLUSH;
                        flush_inc = 1'b1;
                    end else if (load_use) begin
                        ctl       = M_PC_STALL | M_IF_ID_STALL | M_ID_EX_FLUSH;
                        stall_inc = 1'b1;
                    end else begin
                        ctl = M_PC_STALL | M_IF_ID_FLUSH;
                    end
                end
                HALTED: begin
                    ctl    = M_PC_STALL | M_IF_ID_FLUSH;
                    halted = 1'b1;
                end
                default: ctl = '0;
            endcase
        end
    end

    assign pc_stall     = ctl[CTL_PC_STALL];
    assign pc_redirect  = ctl[CTL_PC_REDIRECT];
    assign if_id_stall  = ctl[CTL_IF_ID_STALL];
    assign if_id_flush  = ctl[CTL_IF_ID_FLUSH];
    assign id_ex_stall  = ctl[CTL_ID_EX_STALL];
    assign id_ex_flush  = ctl[CTL_ID_EX_FLUSH];
    assign ex_mem_stall = ctl[CTL_EX_MEM_STALL];
    assign mem_wb_flush = ctl[CTL_MEM_WB_FLUSH];
    assign mem_timeout  = mem_timeout_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (stall_inc),
        .cnt   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (flush_inc),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: per-cycle expectations go through a
// scoreboard queue and are checked with immediate assertions mid-cycle.
module tb_pipe_hazard_ctrl;

    logic        clk, rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_is_load, ex_redirect;
    logic        mem_req, mem_ack, halt_req, resume;
    logic        pc_stall, pc_redirect, if_id_stall, if_id_flush;
    logic        id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush;
    logic        halted, mem_timeout;
    logic [31:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.TIMEOUT(16), .DRAIN_CYC(3), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_rd        (ex_rd),
        .ex_is_load   (ex_is_load),
        .ex_redirect  (ex_redirect),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .halt_req     (halt_req),
        .resume       (resume),
        .pc_stall     (pc_stall),
        .pc_redirect  (pc_redirect),
        .if_id_stall  (if_id_stall),
        .if_id_flush  (if_id_flush),
        .id_ex_stall  (id_ex_stall),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_stall (ex_mem_stall),
        .mem_wb_flush (mem_wb_flush),
        .halted       (halted),
        .mem_timeout  (mem_timeout),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control vector bit order:
    // {mem_wb_flush, ex_mem_stall, id_ex_flush, id_ex_stall, if_id_flush, if_id_stall, pc_redirect, pc_stall}
    localparam int C_NONE   = 'h00;
    localparam int C_FREEZE = 'hD5;
    localparam int C_LU     = 'h25;
    localparam int C_RED    = 'h2A;
    localparam int C_PARK   = 'h09;
    localparam int C_DRED   = 'h2B;
    localparam int SKIP     = -1;

    typedef struct {
        string tag;
        int    ctl;
        int    hlt;
        int    tmo;
        int    st;
        int    fl;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic check(input string tag, input string what, input logic [31:0] obs, input int exp);
        logic [31:0] e;
        if (exp >= 0) begin
            e = exp;
            n_checks++;
            assert (obs === e) else begin
                n_fails++;
                $error("FAIL %s.%s: observed 0x%0h expected 0x%0h", tag, what, obs, e);
            end
        end
    endtask

    // Inputs are already driven for this cycle; queue the expectation, then
    // sample mid-cycle and compare against the popped entry.
    task automatic cyc(input string tag, input int ctl, input int hlt, input int tmo,
                       input int st, input int fl);
        exp_t e;
        logic [31:0] obs_ctl;
        sb.push_back('{tag, ctl, hlt, tmo, st, fl});
        #2;
        e = sb.pop_front();
        obs_ctl = {24'd0, mem_wb_flush, ex_mem_stall, id_ex_flush, id_ex_stall,
                   if_id_flush, if_id_stall, pc_redirect, pc_stall};
        check(e.tag, "ctl", obs_ctl, e.ctl);
        check(e.tag, "halted", {31'd0, halted}, e.hlt);
        check(e.tag, "mem_timeout", {31'd0, mem_timeout}, e.tmo);
        check(e.tag, "stall_cnt", stall_cnt, e.st);
        check(e.tag, "flush_cnt", flush_cnt, e.fl);
        @(negedge clk);
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_is_load = 1'b0; ex_redirect = 1'b0;
        mem_req = 1'b0; mem_ack = 1'b0; halt_req = 1'b0; resume = 1'b0;
    endtask

    // EX: lw x5 ; ID: add x6, x5, x1
    task automatic set_lu();
        idle();
        ex_is_load = 1'b1; ex_rd = 5'd5;
        id_rs1 = 5'd5; id_use_rs1 = 1'b1; id_rs2 = 5'd1; id_use_rs2 = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset holds every control low regardless of inputs.
        ex_redirect = 1'b1; mem_req = 1'b1; halt_req = 1'b1;
        cyc("rst_hold", C_NONE, 0, 0, 0, 0);
        rst = 1'b0;

        idle();                     cyc("idle0", C_NONE, 0, 0, 0, 0);
        set_lu();                   cyc("lu_rs1", C_LU, 0, 0, 0, 0);
        idle(); resume = 1'b1;      cyc("resume_in_run", C_NONE, 0, 0, 1, 0);
        idle(); ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
                                    cyc("lw_x0", C_NONE, 0, 0, 1, 0);
        set_lu(); ex_redirect = 1'b1;
                                    cyc("red_lu", C_RED, 0, 0, 1, 0);
        idle();                     cyc("after_red", C_NONE, 0, 0, 1, 1);
        idle(); ex_is_load = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
        id_rs2 = 5'd7; id_use_rs2 = 1'b1;
                                    cyc("lu_rs2", C_LU, 0, 0, 1, 1);
        id_use_rs2 = 1'b0;          cyc("rs2_unused", C_NONE, 0, 0, 2, 1);

        // Bus wait for 4 cycles, ack on the 5th.
        idle(); mem_req = 1'b1;
        for (int i = 0; i < 4; i++) cyc("mem_wait4", C_FREEZE, 0, 0, 2 + i, 1);
        mem_ack = 1'b1;             cyc("mem_ack", C_NONE, 0, 0, 6, 1);
        idle();                     cyc("after_ack", C_NONE, 0, 0, 6, 1);

        // Bus hang: 16 unacknowledged cycles, then parked with sticky flag.
        mem_req = 1'b1;
        for (int i = 0; i < 16; i++) cyc("hang", C_FREEZE, 0, 0, 6 + i, 1);
                                    cyc("timeout_park", C_PARK, 1, 1, 22, 1);
        idle(); halt_req = 1'b1;    cyc("halt_in_halted", C_PARK, 1, 1, 22, 1);
        idle(); resume = 1'b1;      cyc("resume_cycle", C_PARK, 1, 1, 22, 1);
        idle();                     cyc("resumed", C_NONE, 0, 1, 22, 1);

        // Debug halt: three progress cycles of drain, then parked.
        halt_req = 1'b1;            cyc("halt_req", C_PARK, 0, 1, 22, 1);
        idle();
        for (int i = 0; i < 3; i++) cyc("drain", C_PARK, 0, 1, 22, 1);
                                    cyc("parked", C_PARK, 1, 1, 22, 1);
        resume = 1'b1;              cyc("resume2", C_PARK, 1, 1, 22, 1);
        idle();                     cyc("resumed2", C_NONE, 0, 1, 22, 1);

        // Drain with a redirect (progress) and a 2-cycle bus wait (no progress).
        halt_req = 1'b1;            cyc("halt_req2", C_PARK, 0, 1, 22, 1);
        idle(); ex_redirect = 1'b1; cyc("drain_red", C_DRED, 0, 1, 22, 1);
        idle(); mem_req = 1'b1;
        for (int i = 0; i < 2; i++) cyc("drain_wait", C_FREEZE, 0, 1, 22 + i, 2);
        idle();                     cyc("drain_p2", C_PARK, 0, 1, SKIP, 2);
                                    cyc("drain_p3", C_PARK, 0, 1, SKIP, 2);
                                    cyc("parked2", C_PARK, 1, 1, SKIP, 2);
        resume = 1'b1;              cyc("resume3", C_PARK, 1, 1, SKIP, 2);
        idle();                     cyc("resumed3", C_NONE, 0, 1, SKIP, 2);

        // Reset while waiting on the bus clears everything including the sticky flag.
        mem_req = 1'b1;             cyc("pre_rst_w1", C_FREEZE, 0, 1, SKIP, 2);
                                    cyc("pre_rst_w2", C_FREEZE, 0, 1, SKIP, 2);
        rst = 1'b1; halt_req = 1'b1;
                                    cyc("rst_mid_wait", C_NONE, 0, SKIP, SKIP, SKIP);
        rst = 1'b0; idle();         cyc("post_rst", C_NONE, 0, 0, 0, 0);
        set_lu();                   cyc("post_rst_lu", C_LU, 0, 0, 0, 0);
        idle();                     cyc("post_rst_idle", C_NONE, 0, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
